// File: rtl/cfg_sreg_pkg.sv
// Shared state type and default sizing for the configuration shift-register loader.
package cfg_sreg_pkg;

    localparam int CFG_SREG_WIDTH = 32;
    localparam int CFG_SCLK_DIV   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH
    } state_t;

endpackage

// File: rtl/cfg_sclk_gen.sv
// Phase timer: pulses o_phase_end on the last cycle of every CLKDIV-cycle phase
// while enabled; held at zero when disabled or in reset.
module cfg_sclk_gen
    import cfg_sreg_pkg::*;
#(
    parameter int CLKDIV = CFG_SCLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_phase_end
);

    localparam int            CW   = $clog2(CLKDIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_phase_end;

    assign w_phase_end = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || w_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_phase_end = w_phase_end;

endmodule

// File: rtl/cfg_sreg_loader.sv
// Serializes a parallel configuration word onto sclk_o/sdata_o, captures sdo_i
// for readback and strobes latch_o once the last bit has been shifted.
module cfg_sreg_loader
    import cfg_sreg_pkg::*;
#(
    parameter int WIDTH     = CFG_SREG_WIDTH,
    parameter int CLKDIV    = CFG_SCLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             sclk_o,
    output logic             sdata_o,
    input  logic             sdo_i,
    output logic             latch_o
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, r_rdata, w_sdo_ext, w_cap;
    logic [BW-1:0]    r_bit;
    logic             w_en, w_phase_end, w_accept, w_last_bit;
    logic             r_ready, r_busy, r_done, r_sclk, r_sdata, r_latch;
    logic             w_ready_nxt, w_busy_nxt, w_done_nxt, w_sclk_nxt, w_latch_nxt;

    assign w_en       = (r_state != IDLE);
    assign w_accept   = r_ready && cmd_valid_i;
    assign w_last_bit = (r_bit == LAST_BIT);

    cfg_sclk_gen #(
        .CLKDIV (CLKDIV)
    ) u_sclk_gen (
        .i_clk       (wb_clk_i),
        .i_rst       (wb_rst_i),
        .i_en        (w_en),
        .o_phase_end (w_phase_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = LOW;
            LOW:     if (w_phase_end) w_state_nxt = HIGH;
            HIGH:    if (w_phase_end) w_state_nxt = w_last_bit ? LATCH : LOW;
            LATCH:   if (w_phase_end) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_ready_nxt = !w_busy_nxt;
        w_sclk_nxt  = (w_state_nxt == HIGH);
        w_latch_nxt = (w_state_nxt == LATCH);
        w_done_nxt  = (r_state == LATCH) && w_phase_end;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sclk  <= w_sclk_nxt;
            r_latch <= w_latch_nxt;
        end
    end

    always_comb begin
        w_sdo_ext    = '0;
        w_sdo_ext[0] = sdo_i;
        if (MSB_FIRST) begin
            w_cap = (r_rdata << 1) | w_sdo_ext;
        end else begin
            w_cap = (r_rdata >> 1) | (w_sdo_ext << (WIDTH - 1));
        end
    end

    // The first bit goes straight to sdata_o on accept; r_shift keeps the rest queued.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shift <= '0;
            r_rdata <= '0;
            r_bit   <= '0;
            r_sdata <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= '0;
            r_bit   <= '0;
            if (MSB_FIRST) begin
                r_sdata <= cmd_data_i[WIDTH-1];
                r_shift <= cmd_data_i << 1;
            end else begin
                r_sdata <= cmd_data_i[0];
                r_shift <= cmd_data_i >> 1;
            end
        end else if (w_phase_end) begin
            if (r_state == LOW) begin
                r_rdata <= w_cap;
            end else if ((r_state == HIGH) && !w_last_bit) begin
                r_bit   <= r_bit + BW'(1);
                r_sdata <= MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
                r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
            end
        end
    end

    assign cmd_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign sclk_o      = r_sclk;
    assign sdata_o     = r_sdata;
    assign latch_o     = r_latch;
    assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_cfg_sreg_loader.sv
// Bench for cfg_sreg_loader: a 32-bit MSB-first/CLKDIV=2 instance and a 4-bit
// LSB-first/CLKDIV=1 instance, each looped back through a modelled target register.
module tb_cfg_sreg_loader;

    localparam int DK_A = (2 * 32 + 1) * 2;
    localparam int DK_B = (2 * 4 + 1) * 1;
    localparam int BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [31:0] data_a = '0;
    logic [3:0]  data_b = '0;
    logic        rdy_a, busy_a, done_a, sclk_a, sd_a, sdo_a, latch_a;
    logic        rdy_b, busy_b, done_b, sclk_b, sd_b, sdo_b, latch_b;
    logic [31:0] rd_a;
    logic [3:0]  rd_b;

    // Target shift registers driven by the DUT pins
    logic [31:0] tgt_a = '0;
    logic [3:0]  tgt_b = '0;
    assign sdo_a = tgt_a[31];
    assign sdo_b = tgt_b[0];
    always @(posedge sclk_a) tgt_a <= {tgt_a[30:0], sd_a};
    always @(posedge sclk_b) tgt_b <= {sd_b, tgt_b[3:1]};

    always #5 clk = ~clk;

    cfg_sreg_loader #(.WIDTH(32), .CLKDIV(2), .MSB_FIRST(1'b1)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid_i(valid_a), .cmd_ready_o(rdy_a),
        .cmd_data_i(data_a), .busy_o(busy_a), .done_o(done_a), .rdata_o(rd_a),
        .sclk_o(sclk_a), .sdata_o(sd_a), .sdo_i(sdo_a), .latch_o(latch_a)
    );

    cfg_sreg_loader #(.WIDTH(4), .CLKDIV(1), .MSB_FIRST(1'b0)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid_i(valid_b), .cmd_ready_o(rdy_b),
        .cmd_data_i(data_b), .busy_o(busy_b), .done_o(done_b), .rdata_o(rd_b),
        .sclk_o(sclk_b), .sdata_o(sd_b), .sdo_i(sdo_b), .latch_o(latch_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected {ready,busy,done,sclk,latch} and sdata for k cycles after an accept edge
    function automatic void model_out(input int W, input int DIV, input bit msb, input int k,
                                      input logic [31:0] w, output logic [4:0] ctl,
                                      output logic sd, output logic sd_valid);
        int p, b, dk;
        dk = (2 * W + 1) * DIV;
        p  = k / DIV;
        sd = 1'b0;
        sd_valid = 1'b0;
        if (k < dk) begin
            b   = (p / 2 < W) ? p / 2 : W - 1;
            ctl = {1'b0, 1'b1, 1'b0, (p < 2 * W) && (p % 2 == 1), p == 2 * W};
            sd  = msb ? w[W-1-b] : w[b];
            sd_valid = 1'b1;
        end else if (k == dk) begin
            ctl = 5'b10100;
        end else begin
            ctl = 5'b10000;
        end
    endfunction

    // Transaction model: accept edge, word and expected readback per instance
    logic        have_a = 1'b0, have_b = 1'b0;
    int          tacc_a = 0, tacc_b = 0;
    logic [31:0] word_a = '0, word_b = '0;
    logic [31:0] snap_a = '0;
    logic [3:0]  snap_b = '0;

    always @(posedge clk) begin
        int ka, kb;
        ka = have_a ? cyc - tacc_a : BIG;
        kb = have_b ? cyc - tacc_b : BIG;
        cyc = cyc + 1;
        if (rst) begin
            have_a = 1'b0; snap_a = '0;
            have_b = 1'b0; snap_b = '0;
        end else begin
            if (ka >= DK_A && valid_a) begin
                have_a = 1'b1; tacc_a = cyc; word_a = data_a; snap_a = tgt_a;
            end
            if (kb >= DK_B && valid_b) begin
                have_b = 1'b1; tacc_b = cyc; word_b = {28'b0, data_b}; snap_b = tgt_b;
            end
        end
    end

    always @(negedge clk) begin
        int ka, kb;
        logic [4:0] ec;
        logic es, ev;
        if (cyc > 0) begin
            ka = have_a ? cyc - tacc_a : BIG;
            model_out(32, 2, 1'b1, ka, word_a, ec, es, ev);
            chk("A ctl", {rdy_a, busy_a, done_a, sclk_a, latch_a}, ec);
            if (ev) chk("A sdata", sd_a, es);
            if (ka >= DK_A) chk("A rdata", rd_a, snap_a);
            kb = have_b ? cyc - tacc_b : BIG;
            model_out(4, 1, 1'b0, kb, word_b, ec, es, ev);
            chk("B ctl", {rdy_b, busy_b, done_b, sclk_b, latch_b}, ec);
            if (ev) chk("B sdata", sd_b, es);
            if (kb >= DK_B) chk("B rdata", rd_b, snap_b);
        end
    end

    // Pin monitor: bits at sclk rises, done/latch timing and readback at done
    logic [31:0] m_bits [2];
    logic [31:0] m_rd_done [2];
    int          m_nbits [2], m_ndone [2], m_done_at [2], m_nlatch [2];
    int          m_lat_first [2], m_lat_last [2], m_rise_prev [2], m_period [2];
    logic        m_psclk [2], m_plat [2];

    initial for (int d = 0; d < 2; d++) begin m_psclk[d] = 1'b0; m_plat[d] = 1'b0; end

    always @(negedge clk) begin
        logic s, sd, dn, lt;
        logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            s  = (d == 1) ? sclk_b  : sclk_a;
            sd = (d == 1) ? sd_b    : sd_a;
            dn = (d == 1) ? done_b  : done_a;
            lt = (d == 1) ? latch_b : latch_a;
            rd = (d == 1) ? {28'b0, rd_b} : rd_a;
            if (s === 1'b1 && m_psclk[d] !== 1'b1) begin
                m_bits[d] = {m_bits[d][30:0], sd};
                m_nbits[d]++;
                if (m_rise_prev[d] >= 0) m_period[d] = cyc - m_rise_prev[d];
                m_rise_prev[d] = cyc;
            end
            if (dn === 1'b1) begin
                m_ndone[d]++; m_done_at[d] = cyc; m_rd_done[d] = rd;
            end
            if (lt === 1'b1) begin
                m_nlatch[d]++;
                if (m_plat[d] !== 1'b1) m_lat_first[d] = cyc;
                m_lat_last[d] = cyc;
            end
            m_psclk[d] = s;
            m_plat[d]  = lt;
        end
    end

    task automatic mon_clear();
        for (int d = 0; d < 2; d++) begin
            m_bits[d] = '0; m_rd_done[d] = '0; m_nbits[d] = 0; m_ndone[d] = 0;
            m_done_at[d] = 0; m_nlatch[d] = 0; m_lat_first[d] = 0; m_lat_last[d] = 0;
            m_rise_prev[d] = -1; m_period[d] = 0;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called just after a negedge; t0 is the cycle in which valid&ready was presented
    task automatic send(input int d, input logic [31:0] w, output int t0);
        int n;
        n = 0;
        if (d == 0) begin valid_a = 1'b1; data_a = w; end
        else        begin valid_b = 1'b1; data_b = w[3:0]; end
        while (((d == 0) ? rdy_a : rdy_b) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send ready timeout", {63'b0, ((d == 0) ? rdy_a : rdy_b)}, 64'd1);
        t0 = cyc;
        @(negedge clk);
        if (d == 0) begin valid_a = 1'b0; data_a = $urandom; end
        else        begin valid_b = 1'b0; data_b = 4'($urandom); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        mon_clear();
        repeat (3) @(negedge clk);
        chk("reset ready", rdy_a, 1);
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset sclk", sclk_a, 0);
        chk("reset sdata", sd_a, 0);
        chk("reset latch", latch_a, 0);
        chk("reset rdata", rd_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // 32-bit MSB-first word: bit order, latch window and done timing
        mon_clear();
        tgt_a = 32'h0F0F_1234;
        send(0, 32'hA5C3_0F81, t0);
        wait_cyc(t0 + 140);
        chk("T1 bits", m_bits[0], 32'hA5C3_0F81);
        chk("T1 nbits", m_nbits[0], 32);
        chk("T1 done at", m_done_at[0] - t0, 131);
        chk("T1 ndone", m_ndone[0], 1);
        chk("T1 latch first", m_lat_first[0] - t0, 129);
        chk("T1 latch last", m_lat_last[0] - t0, 130);
        chk("T1 nlatch", m_nlatch[0], 2);
        chk("T1 rdata", m_rd_done[0], 32'h0F0F_1234);

        // Loopback readback
        mon_clear();
        tgt_a = 32'h1234_5678;
        send(0, 32'hDEAD_BEEF, t0);
        wait_cyc(t0 + 140);
        chk("T2 rdata", m_rd_done[0], 32'h1234_5678);
        chk("T2 target", tgt_a, 32'hDEAD_BEEF);
        chk("T2 rdata held", rd_a, 32'h1234_5678);

        // Back-to-back with valid held, then ignored mid-transfer pulses
        mon_clear();
        valid_a = 1'b1;
        data_a  = 32'h3C3C_A5A5;
        t0 = cyc;
        @(negedge clk);
        data_a = 32'h5A5A_0FF0;
        wait_cyc(t0 + 132);
        valid_a = 1'b0;
        data_a  = 32'hFFFF_FFFF;
        wait_cyc(t0 + 150);
        valid_a = 1'b1;
        wait_cyc(t0 + 153);
        valid_a = 1'b0;
        wait_cyc(t0 + 280);
        chk("T3 ndone", m_ndone[0], 2);
        chk("T3 nbits", m_nbits[0], 64);
        chk("T3 second done at", m_done_at[0] - t0, 262);
        chk("T3 second word", m_bits[0], 32'h5A5A_0FF0);
        chk("T3 second rdata", m_rd_done[0], 32'h3C3C_A5A5);

        // Reset mid-transfer, then a clean reload
        mon_clear();
        send(0, 32'hC001_D00D, t0);
        wait_cyc(t0 + 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("T4 ready", rdy_a, 1);
        chk("T4 busy", busy_a, 0);
        chk("T4 done", done_a, 0);
        chk("T4 sclk", sclk_a, 0);
        chk("T4 sdata", sd_a, 0);
        chk("T4 latch", latch_a, 0);
        chk("T4 rdata", rd_a, 0);
        wait_cyc(t0 + 200);
        chk("T4 no done", m_ndone[0], 0);
        chk("T4 no latch", m_nlatch[0], 0);
        mon_clear();
        send(0, 32'h8000_0001, t0);
        wait_cyc(t0 + 140);
        chk("T4 reload bits", m_bits[0], 32'h8000_0001);
        chk("T4 reload ndone", m_ndone[0], 1);
        chk("T4 reload done at", m_done_at[0] - t0, 131);

        // 4-bit LSB-first, CLKDIV=1
        mon_clear();
        tgt_b = 4'b1001;
        send(1, 32'h6, t0);
        wait_cyc(t0 + 20);
        chk("T5 bits", m_bits[1][3:0], 4'b0110);
        chk("T5 nbits", m_nbits[1], 4);
        chk("T5 done at", m_done_at[1] - t0, 10);
        chk("T5 sclk period", m_period[1], 2);
        chk("T5 latch at", m_lat_first[1] - t0, 9);
        chk("T5 nlatch", m_nlatch[1], 1);
        chk("T5 rdata", m_rd_done[1], 32'h9);

        mon_clear();
        send(1, 32'h1, t0);
        wait_cyc(t0 + 20);
        chk("T6 bit order", m_bits[1][3:0], 4'b1000);
        chk("T6 rdata", m_rd_done[1], 32'h6);
        chk("T6 target", tgt_b, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
